// File: rtl/pe_dbuf.sv
// rtl/pe_dbuf.sv - weight-stationary systolic PE with double-buffered weight and optional saturation
package pe_dbuf_pkg;
  typedef enum logic [1:0] {
    PASSTHROUGH = 2'b00,
    LOAD        = 2'b01,
    PROCESS     = 2'b10
  } input_mux_t;
endpackage

module pe_dbuf
  import pe_dbuf_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IN_W-1:0]  left_i,
  input  logic             left_valid_i,
  input  logic [ACC_W-1:0] top_i,
  input  logic             top_valid_i,
  output logic [IN_W-1:0]  right_o,
  output logic             right_valid_o,
  output logic [ACC_W-1:0] bottom_o,
  output logic             bottom_valid_o,
  input  input_mux_t       mux_i,
  input  logic             add_zero_i,
  input  logic             swap_i,
  output logic             shadow_full_o,
  output logic             sat_o,
  input  logic             clr_sat_i
);

  if (ACC_W < 2 * IN_W) begin : g_bad_width
    $error("pe_dbuf: ACC_W must be at least 2*IN_W");
  end

  localparam int PW    = 2 * IN_W;
  localparam int SW    = ACC_W + 1;
  localparam int EXT_W = SW - PW;

  logic [IN_W-1:0]  w_a;
  logic [IN_W-1:0]  w_s;
  logic [PW-1:0]    prod;
  logic [SW-1:0]    prod_x;
  logic [SW-1:0]    add_x;
  logic [SW-1:0]    sum;
  logic [ACC_W-1:0] clamp;
  logic [ACC_W-1:0] result;
  logic             ovf;
  logic             fire;

  // Sign-extending both operands to PW bits makes the truncated product the signed product.
  always_comb begin
    prod   = {{IN_W{SIGNED & w_a[IN_W-1]}}, w_a} * {{IN_W{SIGNED & left_i[IN_W-1]}}, left_i};
    prod_x = {{EXT_W{SIGNED & prod[PW-1]}}, prod};
    add_x  = add_zero_i ? '0 : {SIGNED & top_i[ACC_W-1], top_i};
    sum    = prod_x + add_x;
    ovf    = SIGNED ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
    if (SIGNED) begin
      clamp = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      clamp = '1;
    end
    result = (ovf && SATURATE) ? clamp : sum[ACC_W-1:0];
    fire   = left_valid_i & (add_zero_i | top_valid_i);
  end

  // Later assignments override earlier ones: a load re-fills the shadow after a swap, and a set beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      right_o        <= '0;
      right_valid_o  <= 1'b0;
      bottom_o       <= '0;
      bottom_valid_o <= 1'b0;
      w_a            <= '0;
      w_s            <= '0;
      shadow_full_o  <= 1'b0;
      sat_o          <= 1'b0;
    end else begin
      right_o       <= left_i;
      right_valid_o <= left_valid_i;
      if (swap_i && shadow_full_o) begin
        w_a           <= w_s;
        shadow_full_o <= 1'b0;
      end
      if (clr_sat_i) begin
        sat_o <= 1'b0;
      end
      case (mux_i)
        PASSTHROUGH: begin
          bottom_o       <= top_i;
          bottom_valid_o <= top_valid_i;
        end
        LOAD: begin
          bottom_valid_o <= 1'b0;
          if (top_valid_i) begin
            w_s           <= top_i[IN_W-1:0];
            shadow_full_o <= 1'b1;
          end
        end
        PROCESS: begin
          bottom_valid_o <= fire;
          if (fire) begin
            bottom_o <= result;
            if (ovf && SATURATE) begin
              sat_o <= 1'b1;
            end
          end
        end
        default: begin
          bottom_o       <= top_i;
          bottom_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dbuf.sv
// tb/tb_pe_dbuf.sv - bench for pe_dbuf across signed/unsigned, wrap/saturate and 16/32-bit accumulators
module tb_pe_dbuf;
  import pe_dbuf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  left;
  logic        lv;
  logic [31:0] top;
  logic        tv;
  input_mux_t  mux;
  logic        az;
  logic        swap;
  logic        clr;

  logic [7:0]  rgt [4];
  logic        rv  [4];
  logic        bv  [4];
  logic        sf  [4];
  logic        sat [4];
  logic [31:0] bot0;
  logic [15:0] bot1, bot2, bot3;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] PT = 2'd0, LD = 2'd1, PR = 2'd2, BAD = 2'd3;

  pe_dbuf #(.IN_W(8), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst), .left_i(left), .left_valid_i(lv), .top_i(top), .top_valid_i(tv),
    .right_o(rgt[0]), .right_valid_o(rv[0]), .bottom_o(bot0), .bottom_valid_o(bv[0]),
    .mux_i(mux), .add_zero_i(az), .swap_i(swap), .shadow_full_o(sf[0]), .sat_o(sat[0]), .clr_sat_i(clr));
  pe_dbuf #(.IN_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .left_i(left), .left_valid_i(lv), .top_i(top[15:0]), .top_valid_i(tv),
    .right_o(rgt[1]), .right_valid_o(rv[1]), .bottom_o(bot1), .bottom_valid_o(bv[1]),
    .mux_i(mux), .add_zero_i(az), .swap_i(swap), .shadow_full_o(sf[1]), .sat_o(sat[1]), .clr_sat_i(clr));
  pe_dbuf #(.IN_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0)) u2 (
    .clk_i(clk), .rst_i(rst), .left_i(left), .left_valid_i(lv), .top_i(top[15:0]), .top_valid_i(tv),
    .right_o(rgt[2]), .right_valid_o(rv[2]), .bottom_o(bot2), .bottom_valid_o(bv[2]),
    .mux_i(mux), .add_zero_i(az), .swap_i(swap), .shadow_full_o(sf[2]), .sat_o(sat[2]), .clr_sat_i(clr));
  pe_dbuf #(.IN_W(8), .ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b1)) u3 (
    .clk_i(clk), .rst_i(rst), .left_i(left), .left_valid_i(lv), .top_i(top[15:0]), .top_valid_i(tv),
    .right_o(rgt[3]), .right_valid_o(rv[3]), .bottom_o(bot3), .bottom_valid_o(bv[3]),
    .mux_i(mux), .add_zero_i(az), .swap_i(swap), .shadow_full_o(sf[3]), .sat_o(sat[3]), .clr_sat_i(clr));

  // Reference model: exact integer arithmetic, range check against the accumulator's representable span.
  int      aw [4] = '{32, 16, 16, 16};
  bit      sg [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit      st [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  longint  m_wa [4], m_ws [4], m_bot [4], m_right [4];
  bit      m_sf [4], m_sat [4], m_bv [4], m_rv [4];

  function automatic longint as_int(longint raw, int w, bit s);
    longint v;
    v = raw & ((longint'(1) << w) - 1);
    if (s && (((v >> (w - 1)) & 1) == 1)) v = v - (longint'(1) << w);
    return v;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      longint mask, tk, wa, ws, sum, lo, hi;
      bit f;
      mask = (longint'(1) << aw[k]) - 1;
      tk   = longint'(top) & mask;
      if (rst) begin
        m_wa[k] = 0; m_ws[k] = 0; m_bot[k] = 0; m_right[k] = 0;
        m_sf[k] = 0; m_sat[k] = 0; m_bv[k] = 0; m_rv[k] = 0;
      end else begin
        wa = m_wa[k]; ws = m_ws[k]; f = m_sf[k];
        m_right[k] = longint'(left);
        m_rv[k]    = lv;
        if (swap && f) begin
          m_wa[k] = ws;
          m_sf[k] = 1'b0;
        end
        if (clr) m_sat[k] = 1'b0;
        m_bv[k] = 1'b0;
        case (mux)
          PASSTHROUGH: begin
            m_bot[k] = tk;
            m_bv[k]  = tv;
          end
          LOAD: begin
            if (tv) begin
              m_ws[k] = longint'(top) & 255;
              m_sf[k] = 1'b1;
            end
          end
          PROCESS: begin
            if (lv && (az || tv)) begin
              sum = as_int(wa, 8, sg[k]) * as_int(longint'(left), 8, sg[k]) + (az ? 0 : as_int(tk, aw[k], sg[k]));
              lo  = sg[k] ? -(longint'(1) << (aw[k] - 1)) : 0;
              hi  = sg[k] ? ((longint'(1) << (aw[k] - 1)) - 1) : mask;
              if ((sum > hi || sum < lo) && st[k]) begin
                m_bot[k] = (sum > hi ? hi : lo) & mask;
                m_sat[k] = 1'b1;
              end else begin
                m_bot[k] = sum & mask;
              end
              m_bv[k] = 1'b1;
            end
          end
          default: m_bot[k] = tk;
        endcase
      end
    end
  endtask

  function automatic logic [63:0] get_bot(int k);
    case (k)
      0:       return {32'd0, bot0};
      1:       return {48'd0, bot1};
      2:       return {48'd0, bot2};
      default: return {48'd0, bot3};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("right%0d", k),  {56'd0, rgt[k]}, m_right[k]);
      chk($sformatf("rvalid%0d", k), {63'd0, rv[k]},  {63'd0, m_rv[k]});
      chk($sformatf("bottom%0d", k), get_bot(k),      m_bot[k]);
      chk($sformatf("bvalid%0d", k), {63'd0, bv[k]},  {63'd0, m_bv[k]});
      chk($sformatf("sfull%0d", k),  {63'd0, sf[k]},  {63'd0, m_sf[k]});
      chk($sformatf("sat%0d", k),    {63'd0, sat[k]}, {63'd0, m_sat[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic [1:0] m, input logic [7:0] l, input logic lvi, input logic [31:0] t,
                        input logic tvi, input logic azi, input logic sw, input logic cl);
    mux = input_mux_t'(m); left = l; lv = lvi; top = t; tv = tvi; az = azi; swap = sw; clr = cl;
  endtask

  task automatic load_swap(input logic [7:0] w);
    set_in(LD, 8'd0, 1'b0, {24'd0, w}, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(PT, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);     tick();
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  mux;
    logic [7:0]  left;
    logic        lv;
    logic [31:0] top;
    logic        tv;
    logic        az;
    logic        swap;
    logic        clr;
    logic [31:0] eb;
    logic        ebv;
    logic        esf;
  } vec_t;

  vec_t tbl [$];

  initial begin
    // Expected values refer to the 32-bit signed saturating instance.
    tbl.push_back('{1'b0, LD,  8'd0, 1'b0, 32'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1});
    tbl.push_back('{1'b0, PT,  8'd0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0});
    tbl.push_back('{1'b0, LD,  8'd0, 1'b0, 32'd7,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1});
    tbl.push_back('{1'b0, PR,  8'd2, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 1'b1});
    tbl.push_back('{1'b0, PT,  8'd0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd2, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd24, 1'b1, 1'b0});
    tbl.push_back('{1'b0, LD,  8'd0, 1'b0, 32'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'd24, 1'b0, 1'b1});
    tbl.push_back('{1'b0, LD,  8'd0, 1'b0, 32'd9,  1'b1, 1'b0, 1'b1, 1'b0, 32'd24, 1'b0, 1'b1});
    tbl.push_back('{1'b0, PR,  8'd1, 1'b1, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd5,  1'b1, 1'b1});
    tbl.push_back('{1'b0, PR,  8'd1, 1'b1, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'd5,  1'b1, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd1, 1'b1, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd9,  1'b1, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd1, 1'b1, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'd9,  1'b1, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd1, 1'b1, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd9,  1'b1, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd3, 1'b1, 32'd1,  1'b0, 1'b0, 1'b0, 1'b0, 32'd9,  1'b0, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd3, 1'b0, 32'd1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd9,  1'b0, 1'b0});
    tbl.push_back('{1'b0, LD,  8'd0, 1'b0, 32'd4,  1'b1, 1'b0, 1'b0, 1'b0, 32'd9,  1'b0, 1'b1});
    tbl.push_back('{1'b0, PT,  8'd0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd5, 1'b1, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 1'b0});
    tbl.push_back('{1'b0, BAD, 8'd0, 1'b0, 32'd123, 1'b1, 1'b0, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0});
    tbl.push_back('{1'b0, PT,  8'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, LD,  8'd0, 1'b0, 32'd6,  1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1});
    tbl.push_back('{1'b1, PR,  8'd5, 1'b1, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 1'b0});
    tbl.push_back('{1'b0, PR,  8'd5, 1'b1, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0});

    rst = 1'b1;
    set_in(PT, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("reset_bottom0", {32'd0, bot0}, 64'd0);
    chk("reset_right0", {56'd0, rgt[0]}, 64'd0);
    chk("reset_sfull0", {63'd0, sf[0]}, 64'd0);
    rst = 1'b0;
    tick();

    for (int m = 0; m < 4; m++) begin
      set_in(m[1:0], 8'h5A, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("blane_right_mode%0d", m), {56'd0, rgt[0]}, 64'h5A);
        chk($sformatf("blane_valid_mode%0d", m), {63'd0, rv[0]}, 64'd1);
      end
    end

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      set_in(tbl[i].mux, tbl[i].left, tbl[i].lv, tbl[i].top, tbl[i].tv, tbl[i].az, tbl[i].swap, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d_bottom", i), {32'd0, bot0}, {32'd0, tbl[i].eb});
      chk($sformatf("tbl%0d_bvalid", i), {63'd0, bv[0]}, {63'd0, tbl[i].ebv});
      chk($sformatf("tbl%0d_sfull", i),  {63'd0, sf[0]}, {63'd0, tbl[i].esf});
    end
    rst = 1'b0;

    load_swap(8'h80);
    set_in(PR, 8'h80, 1'b1, 32'h00007FFF, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("satpos_bot0", {32'd0, bot0}, 64'hBFFF);
    chk("satpos_bot1", {48'd0, bot1}, 64'h7FFF);
    chk("satpos_sat1", {63'd0, sat[1]}, 64'd1);
    chk("satpos_bot2", {48'd0, bot2}, 64'hBFFF);
    chk("satpos_sat2", {63'd0, sat[2]}, 64'd0);
    chk("satpos_bot3", {48'd0, bot3}, 64'hBFFF);
    set_in(PR, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("clrsat_sat1", {63'd0, sat[1]}, 64'd0);

    load_swap(8'h7F);
    set_in(PR, 8'h80, 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("satneg_bot0", {32'd0, bot0}, 64'hFFFF4080);
    chk("satneg_bot1", {48'd0, bot1}, 64'h8000);
    chk("satneg_sat1", {63'd0, sat[1]}, 64'd1);
    chk("satneg_bot2", {48'd0, bot2}, 64'h4080);
    chk("satneg_bot3", {48'd0, bot3}, 64'hBF80);
    set_in(PR, 8'h80, 1'b1, 32'hFFFF8000, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    chk("setwins_sat1", {63'd0, sat[1]}, 64'd1);

    load_swap(8'hFF);
    set_in(PR, 8'hFF, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("usat_bot3", {48'd0, bot3}, 64'hFFFF);
    chk("usat_sat3", {63'd0, sat[3]}, 64'd1);
    chk("usat_bot1", {48'd0, bot1}, 64'h0);
    chk("usat_bot0", {32'd0, bot0}, 64'h10000);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      r   = $urandom;
      rst = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0:       top = r;
        1:       top = {24'h7FFFFF, r[7:0]};
        2:       top = {24'h800000, r[7:0]};
        default: top = {16'd0, r[15:0]};
      endcase
      mux  = input_mux_t'(2'($urandom_range(0, 3)));
      left = 8'($urandom);
      lv   = ($urandom_range(0, 3) != 0);
      tv   = ($urandom_range(0, 3) != 0);
      az   = ($urandom_range(0, 3) == 0);
      swap = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_dbuf.md
# pe_dbuf

Parametrised weight-stationary processing element for the systolic matrix-multiply array. It is the drop-in successor of the single-weight PE. It adds configurable operand and accumulator widths, signed or unsigned arithmetic, and optional saturation with a sticky flag. It also adds per-lane valid bits and a double-buffered (shadow/active) weight, so the next tile's weights load while the current tile computes.

## Interface
- IN_W, 8, operand/weight width (left/right lanes, weights)
- ACC_W, 32, partial-sum width (top/bottom lanes); elaboration error if ACC_W < 2*IN_W
- SIGNED, 1, 1 = two's-complement operands and sums; 0 = unsigned
- SATURATE, 1, 1 = clamp on accumulate overflow; 0 = wrap modulo 2^ACC_W

- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset; synchronous and active-high
- left_i  in  IN_W  streaming operand B
- left_valid_i  in  1  left_i qualifier
- top_i  in  ACC_W  partial sum C from above; in LOAD mode, weight on top_i[IN_W-1:0]
- top_valid_i  in  1  top_i qualifier
- right_o  out  IN_W  registered copy of left_i
- right_valid_o  out  1  registered copy of left_valid_i
- bottom_o  out  ACC_W  registered result or passthrough
- bottom_valid_o  out  1  bottom_o qualifier
- mux_i  in  input_mux_t  PASSTHROUGH / LOAD / PROCESS (from pkg)
- add_zero_i  in  1  high: ignore top_i, result = product only
- swap_i  in  1  promote shadow weight to active
- shadow_full_o  out  1  shadow weight loaded and not yet swapped
- sat_o  out  1  sticky saturation flag
- clr_sat_i  in  1  clear sat_o

## Operation
- State: active weight W_A, shadow weight W_S, shadow_full, sat.
- Reset values: right_o, bottom_o, W_A and W_S all zero; all valids zero; shadow_full and sat_o zero.
- B lane: every cycle, regardless of mux_i, right_o <= left_i and right_valid_o <= left_valid_i.
- PASSTHROUGH: bottom_o <= top_i; bottom_valid_o <= top_valid_i.
- LOAD: if top_valid_i, then W_S <= top_i[IN_W-1:0] and shadow_full <= 1. Otherwise no change. bottom_valid_o <= 0; bottom_o holds.
- PROCESS: fire = left_valid_i & (add_zero_i | top_valid_i).
  - If fire: bottom_o <= result and bottom_valid_o <= 1.
  - Otherwise: bottom_valid_o <= 0 and bottom_o holds.
- swap_i:
  - Valid in any mode.
  - If shadow_full: W_A <= W_S and shadow_full <= 0.
  - If not shadow_full: no-op, and W_A holds.
- swap_i together with a LOAD write in the same cycle:
  - W_A <= old W_S, if shadow_full was set.
  - W_S <= new weight, and shadow_full ends at 1.
  - If shadow_full was 0, the swap is a no-op and only the load happens.
- The weight used by PROCESS in a given cycle is W_A before that cycle's swap; a swap takes effect the following cycle.
- Arithmetic:
  - product = W_A * left_i (IN_W x IN_W to 2*IN_W), signed if SIGNED.
  - The product is extended to ACC_W+1 bits: sign-extended if SIGNED, zero-extended otherwise.
  - addend = 0 if add_zero_i, else top_i, extended the same way.
  - sum = product + addend, computed in ACC_W+1 bits.
- Overflow detection:
  - Signed: sum[ACC_W] != sum[ACC_W-1].
  - Unsigned: sum[ACC_W] == 1.
- On overflow:
  - SATURATE=1: result clamps. Signed clamps to 2^(ACC_W-1)-1 if positive, -2^(ACC_W-1) if negative. Unsigned clamps to 2^ACC_W-1.
  - SATURATE=0: result = sum[ACC_W-1:0].
- sat flag:
  - Set on any firing PROCESS cycle that overflows, when SATURATE=1.
  - Stays 0 when SATURATE=0.
  - clr_sat_i clears it. Clear and set in the same cycle: set wins.
- Unknown/illegal mux_i encoding behaves as PASSTHROUGH with bottom_valid_o forced to 0.

## Timing
- All outputs are registered; latency is 1 cycle from any input to right_o, bottom_o and the valids.
- No combinational input-to-output path.
- shadow_full_o reflects the load/swap of the previous edge.
- Reset mid-operation:
  - The next edge returns every register to its reset value, including both weights.
  - An in-flight swap or load in the reset cycle is discarded.
- No backpressure; the array controller owns scheduling.

## Test plan
- Reset, then idle: all outputs 0. Drive left_i=0x5A with valid for 3 cycles; right_o=0x5A and right_valid_o=1 one cycle later, in every mux_i mode.
- Double buffer (IN_W=8, ACC_W=32, signed):
  - LOAD 3, then swap; shadow_full_o goes 1 then 0.
  - LOAD 7 (no swap); PROCESS with left_i=2, top_i=10 gives bottom_o=16.
  - Swap, then the same stimulus gives bottom_o=24.
- Simultaneous LOAD 9 and swap with W_S=5 pending: next cycle W_A=5, W_S=9, shadow_full_o=1. A swap with shadow_full_o=0 leaves W_A unchanged.
- Signed saturation (ACC_W=16):
  - W_A=-128, left_i=-128, top_i=32767 gives bottom_o=32767 and sat_o=1.
  - W_A=127, left_i=-128, top_i=-32768 gives bottom_o=-32768.
  - clr_sat_i drops sat_o. With SATURATE=0, the first case gives bottom_o=0xBFFF (49151 as raw bits).
- Valid gating:
  - PROCESS with left_valid_i=1, top_valid_i=0, add_zero_i=0: bottom_valid_o=0 and bottom_o holds.
  - Same with add_zero_i=1, W_A=4, left_i=5: bottom_o=20, valid=1.
  - Unsigned (SIGNED=0, IN_W=8, ACC_W=16): 255*255 + 0xFFFF saturates to 0xFFFF.
- Reset asserted mid-PROCESS stream with shadow_full_o=1: next cycle all outputs and weights are 0. A following PROCESS with add_zero_i=1 gives bottom_o=0.
